// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the round-robin constant-multiply scheduler.
package mul_sched_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_OW = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S3   = 2'd1,
    S7   = 2'd2,
    S8   = 2'd3
  } state_t;

  localparam logic [1:0] PH_X1 = 2'd0;
  localparam logic [1:0] PH_X3 = 2'd1;
  localparam logic [1:0] PH_X7 = 2'd2;
  localparam logic [1:0] PH_X8 = 2'd3;

endpackage

// File: rtl/mul_sched_if.sv
// Requester handshake and tagged result bus of the multiply scheduler.
interface mul_sched_if import mul_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [OW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
  logic [1:0]         out_phase;
  logic               out_last;
  logic               busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, out_valid, out_data, out_id, out_phase, out_last, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, out_valid, out_data, out_id, out_phase, out_last, busy
  );

endinterface

// File: rtl/mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Shares one shift-add datapath among NREQ requesters, emitting d*1, d*3, d*7, d*8
// on consecutive cycles, each tagged with requester id and phase.
module mul_sched import mul_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int DW   = DEF_DW,
  parameter int OW   = DEF_OW
) (
  input logic       clk,
  input logic       rst,
  mul_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr, gnt_id;
  logic [NREQ-1:0] gnt;
  logic [DW-1:0]   d_reg, d_sel;
  logic [OW-1:0]   d_ext;
  logic            arb_en, accept;

  logic            out_valid, out_valid_nx;
  logic [OW-1:0]   out_data, out_data_nx;
  logic [IDW-1:0]  out_id, out_id_nx;
  logic [1:0]      out_phase, out_phase_nx;
  logic            out_last, out_last_nx;

  // Gating with rst keeps req_ready low while reset is held.
  assign arb_en = (state == IDLE) && rst;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req_valid),
    .ptr    (ptr),
    .enable (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept = |gnt;
  assign d_sel  = bus.req_data[int'(gnt_id)*DW +: DW];
  assign d_ext  = OW'(d_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    out_valid_nx = out_valid;
    out_data_nx  = out_data;
    out_id_nx    = out_id;
    out_phase_nx = out_phase;
    out_last_nx  = out_last;
    case (state)
      IDLE: begin
        out_last_nx = 1'b0;
        if (accept) begin
          state_nx     = S3;
          out_valid_nx = 1'b1;
          out_data_nx  = OW'(d_sel);
          out_id_nx    = gnt_id;
          out_phase_nx = PH_X1;
        end else begin
          out_valid_nx = 1'b0;
        end
      end
      S3: begin
        state_nx     = S7;
        out_data_nx  = (d_ext << 1) + d_ext;
        out_phase_nx = PH_X3;
      end
      S7: begin
        state_nx     = S8;
        out_data_nx  = (d_ext << 3) - d_ext;
        out_phase_nx = PH_X7;
      end
      S8: begin
        state_nx     = IDLE;
        out_data_nx  = d_ext << 3;
        out_phase_nx = PH_X8;
        out_last_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= IDW'(NREQ - 1);
      d_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_phase <= '0;
      out_last  <= 1'b0;
    end else begin
      if (accept) begin
        ptr   <= gnt_id;
        d_reg <= d_sel;
      end
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      out_id    <= out_id_nx;
      out_phase <= out_phase_nx;
      out_last  <= out_last_nx;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_id    = out_id;
  assign bus.out_phase = out_phase;
  assign bus.out_last  = out_last;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int OW   = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mul_sched_if #(.NREQ(NREQ), .DW(DW), .OW(OW)) bus ();

  mul_sched #(.NREQ(NREQ), .DW(DW), .OW(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int id;
    int d;
    int x1;
    int x3;
    int x7;
    int x8;
  } vec_t;
  vec_t tbl[5];

  typedef struct {
    int data;
    int id;
    int ph;
  } res_t;
  res_t q[$];
  res_t e;

  int mult[4] = '{1, 3, 7, 8};
  int mptr, g, r;
  logic [NREQ-1:0] v;
  logic [7:0]      dd[NREQ];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // {valid, data, id, phase, last}
  function automatic logic [31:0] obs();
    return {15'b0, bus.out_valid, bus.out_data, bus.out_id, bus.out_phase, bus.out_last};
  endfunction

  function automatic logic [31:0] ex(bit vld, int data, int id, int ph, bit last);
    return {15'b0, vld, 11'(data), 2'(id), 2'(ph), last};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    rst = 1'b0;
    #1;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0, 8'h05, 5, 15, 35, 40};
    tbl[1] = '{2, 8'hFF, 255, 765, 1785, 2040};
    tbl[2] = '{1, 8'h00, 0, 0, 0, 0};
    tbl[3] = '{3, 100, 100, 300, 700, 800};
    tbl[4] = '{1, 128, 128, 384, 896, 1024};

    bus.req_valid = '0;
    bus.req_data  = '0;

    // Reset state, with requests pending while reset is held
    #2 rst = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_out", obs(), 0);
    chk("rst_busy", bus.busy, 0);
    step();
    chk("rst_ready2", bus.req_ready, 0);
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_out", obs(), 0);

    // Table of single-requester sequences
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 4'(1 << tbl[i].id);
      bus.req_data  = '0;
      bus.req_data[tbl[i].id*DW +: DW] = 8'(tbl[i].d);
      #1;
      chk("tbl_ready", bus.req_ready, 1 << tbl[i].id);
      step();
      bus.req_valid = '0;
      chk("tbl_x1", obs(), ex(1, tbl[i].x1, tbl[i].id, 0, 0));
      chk("tbl_busy", bus.busy, 1);
      step();
      chk("tbl_x3", obs(), ex(1, tbl[i].x3, tbl[i].id, 1, 0));
      step();
      chk("tbl_x7", obs(), ex(1, tbl[i].x7, tbl[i].id, 2, 0));
      step();
      chk("tbl_x8", obs(), ex(1, tbl[i].x8, tbl[i].id, 3, 1));
      chk("tbl_idle_busy", bus.busy, 0);
    end
    step();
    chk("tbl_drain", {bus.out_valid, bus.out_last}, 0);

    // All requesters pending: grants 0,1,2,3,0 with continuous out_valid
    do_reset();
    bus.req_valid = '1;
    for (int k = 0; k < NREQ; k++) bus.req_data[k*DW +: DW] = 8'(k + 1);
    #1;
    chk("rr_first_ready", bus.req_ready, 1);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("rr_out", obs(), ex(1, ((c/4)%4 + 1) * mult[c%4], (c/4)%4, c%4, (c%4) == 3));
      if (c % 4 == 3) chk("rr_ready", bus.req_ready, 1 << (((c/4) + 1) % 4));
      else            chk("rr_ready", bus.req_ready, 0);
    end

    // Late arrival during S7 is granted exactly in the cycle showing x8
    do_reset();
    bus.req_valid = 4'b1000;
    bus.req_data  = '0;
    bus.req_data[3*DW +: DW] = 8'd9;
    #1;
    chk("late_ready3", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    step();
    bus.req_valid = 4'b0010;
    bus.req_data[1*DW +: DW] = 8'h21;
    #1;
    chk("late_ready_s7", bus.req_ready, 0);
    step();
    chk("late_ready_s8", bus.req_ready, 0);
    step();
    chk("late_x8", obs(), ex(1, 72, 3, 3, 1));
    chk("late_ready_idle", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = '0;
    chk("late_x1", obs(), ex(1, 8'h21, 1, 0, 0));

    // Reset asserted in S7 clears outputs immediately
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out", obs(), 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.req_ready, 0);
    step();
    rst = 1'b1;
    bus.req_valid = 4'b1000;
    bus.req_data[3*DW +: DW] = 8'h10;
    #1;
    chk("midrst_ready3", bus.req_ready, 4'b1000);
    step();
    bus.req_valid = '0;
    chk("midrst_x1", obs(), ex(1, 16, 3, 0, 0));
    step();
    chk("midrst_x3", obs(), ex(1, 48, 3, 1, 0));
    step();
    step();

    // Requester 2 withdraws before its grant; requester 0 is served
    do_reset();
    bus.req_valid = 4'b0010;
    bus.req_data[1*DW +: DW] = 8'd7;
    #1;
    chk("drop_ready1", bus.req_ready, 4'b0010);
    step();
    bus.req_valid = 4'b0101;
    bus.req_data[0*DW +: DW] = 8'h40;
    bus.req_data[2*DW +: DW] = 8'h30;
    step();
    step();
    bus.req_valid = 4'b0001;
    step();
    #1;
    chk("drop_x8", obs(), ex(1, 56, 1, 3, 1));
    chk("drop_ready0", bus.req_ready, 4'b0001);
    step();
    bus.req_valid = '0;
    chk("drop_x1", obs(), ex(1, 8'h40, 0, 0, 0));
    for (int c = 0; c < 6; c++) begin
      step();
      chk("drop_no_id2", (bus.out_valid && bus.out_id == 2), 0);
    end

    // Random traffic against the reference model
    do_reset();
    mptr = NREQ - 1;
    v    = '0;
    q.delete();
    for (int k = 0; k < NREQ; k++) dd[k] = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!v[k] && $urandom_range(0, 3) == 0) begin
          v[k]  = 1'b1;
          dd[k] = 8'($urandom);
        end
      end
      bus.req_valid = v;
      for (int k = 0; k < NREQ; k++) bus.req_data[k*DW +: DW] = dd[k];
      #1;
      g = -1;
      if (q.size() == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          r = (mptr + k) % NREQ;
          if (g < 0 && v[r]) g = r;
        end
      end
      chk("rnd_ready", bus.req_ready, (g < 0) ? 0 : (1 << g));
      step();
      if (g >= 0) begin
        for (int ph = 0; ph < 4; ph++) q.push_back('{int'(dd[g]) * mult[ph], g, ph});
        mptr = g;
        v[g] = 1'b0;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rnd_out", obs(), ex(1, e.data, e.id, e.ph, e.ph == 3));
      end else begin
        chk("rnd_idle", {bus.out_valid, bus.out_last}, 0);
      end
      chk("rnd_busy", bus.busy, q.size() > 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
